// File: rtl/gpu_pkg.sv
// Shared register map and FSM encoding for the sprite engine.
package gpu_pkg;

    localparam logic [19:0] SPR_BASE    = 20'h68000;
    localparam logic [19:0] BG_ADDR     = 20'h68800;
    localparam logic [19:0] KEY_ADDR    = 20'h68804;
    localparam logic [19:0] STATUS_ADDR = 20'h68808;

    localparam logic [3:0] REG_X        = 4'h0;
    localparam logic [3:0] REG_Y        = 4'h4;
    localparam logic [3:0] REG_TEX_BASE = 4'h8;
    localparam logic [3:0] REG_CTRL     = 4'hC;

    typedef enum logic [2:0] {
        StIdle,
        StHost,
        StScan,
        StTexWait,
        StEmit
    } state_t;

    // Sprite window covers up to 32 channels of 16 bytes each, word-aligned only.
    function automatic logic in_sprite_window(input logic [19:0] off);
        return (off[19:9] == SPR_BASE[19:9]) && (off[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/gpu_sprite_hit.sv
// Combinational hit test of one sprite against the cursor, plus texel address.
module gpu_sprite_hit #(
    parameter int unsigned COORD_W  = 10,
    parameter int unsigned SPR_LOG2 = 4,
    parameter int unsigned TEX_AW   = 16
) (
    input  logic [COORD_W-1:0] hcursor_i,
    input  logic [COORD_W-1:0] vcursor_i,
    input  logic [COORD_W-1:0] spr_x_i,
    input  logic [COORD_W-1:0] spr_y_i,
    input  logic               enable_i,
    input  logic [TEX_AW-1:0]  tex_base_i,
    output logic               hit_o,
    output logic [TEX_AW-1:0]  tex_adr_o
);

    logic [COORD_W:0]       dx_full;
    logic [COORD_W:0]       dy_full;
    logic [2*SPR_LOG2-1:0]  texel_off;

    // One extra bit keeps a cursor left of/above the sprite negative instead of wrapping.
    assign dx_full = {1'b0, hcursor_i} - {1'b0, spr_x_i};
    assign dy_full = {1'b0, vcursor_i} - {1'b0, spr_y_i};

    assign hit_o = enable_i
                   && (dx_full[COORD_W:SPR_LOG2] == '0)
                   && (dy_full[COORD_W:SPR_LOG2] == '0);

    assign texel_off = {dy_full[SPR_LOG2-1:0], dx_full[SPR_LOG2-1:0]};
    assign tex_adr_o = tex_base_i + TEX_AW'(texel_off);

endmodule

// File: rtl/gpu_sprite_engine.sv
// Sprite compositor: host register bus, one-deep pixel request slot, priority scan
// over sprite channels with colour-keyed texel fetch.
module gpu_sprite_engine
    import gpu_pkg::*;
#(
    parameter int unsigned NUM_SPRITES = 8,
    parameter int unsigned COORD_W     = 10,
    parameter int unsigned COLOR_W     = 24,
    parameter int unsigned SPR_LOG2    = 4,
    parameter int unsigned TEX_AW      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] hcursor_i,
    input  logic [COORD_W-1:0] vcursor_i,
    input  logic               cursor_valid_i,
    output logic [COLOR_W-1:0] pixel_o,
    output logic               pixel_ready_o,
    input  logic               stb_i,
    input  logic               cyc_i,
    input  logic               we_i,
    input  logic [31:0]        adr_i,
    input  logic [31:0]        dat_i,
    output logic [31:0]        dat_o,
    output logic               ack_o,
    output logic               tex_stb_o,
    output logic [TEX_AW-1:0]  tex_adr_o,
    input  logic               tex_ack_i,
    input  logic [COLOR_W-1:0] tex_dat_i
);

    localparam int unsigned      IDX_W    = $clog2(NUM_SPRITES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);

    logic [COORD_W-1:0] spr_x_q    [NUM_SPRITES];
    logic [COORD_W-1:0] spr_y_q    [NUM_SPRITES];
    logic [TEX_AW-1:0]  spr_base_q [NUM_SPRITES];
    logic               spr_en_q   [NUM_SPRITES];
    logic [COLOR_W-1:0] bg_q;
    logic [COLOR_W-1:0] key_q;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               pend_q;
    logic [COORD_W-1:0] pend_x_q, pend_y_q;
    logic               overrun_q;
    logic               host_hold_q;

    logic [COLOR_W-1:0] pixel_q, pixel_d;
    logic               ready_q, ready_d;
    logic               ack_q, ack_d;
    logic [31:0]        dat_q, dat_d;
    logic               tex_stb_q, tex_stb_d;
    logic [TEX_AW-1:0]  tex_adr_q, tex_adr_d;

    logic [19:0]        off;
    logic [4:0]         spr_idx;
    logic               spr_sel;
    logic               host_wr;
    logic               status_clr;
    logic               emit;
    logic               drop;
    logic [31:0]        rd_data;
    logic               hit;
    logic [TEX_AW-1:0]  hit_adr;
    logic               unused_bits;

    assign off        = adr_i[19:0];
    assign spr_idx    = off[8:4];
    assign spr_sel    = in_sprite_window(off) && (32'(spr_idx) < NUM_SPRITES);
    assign host_wr    = (state_q == StHost) && we_i;
    assign status_clr = (state_q == StHost) && !we_i && (off == STATUS_ADDR);
    assign emit       = (state_q == StEmit);
    assign drop       = cursor_valid_i && pend_q && !emit;
    assign unused_bits = ^{adr_i[31:20], dat_i};

    assign pixel_o       = pixel_q;
    assign pixel_ready_o = ready_q;
    assign dat_o         = dat_q;
    assign ack_o         = ack_q;
    assign tex_stb_o     = tex_stb_q;
    assign tex_adr_o     = tex_adr_q;

    gpu_sprite_hit #(
        .COORD_W  (COORD_W),
        .SPR_LOG2 (SPR_LOG2),
        .TEX_AW   (TEX_AW)
    ) u_hit (
        .hcursor_i  (pend_x_q),
        .vcursor_i  (pend_y_q),
        .spr_x_i    (spr_x_q[idx_q]),
        .spr_y_i    (spr_y_q[idx_q]),
        .enable_i   (spr_en_q[idx_q]),
        .tex_base_i (spr_base_q[idx_q]),
        .hit_o      (hit),
        .tex_adr_o  (hit_adr)
    );

    always_comb begin
        rd_data = '0;
        if (spr_sel) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (spr_idx == 5'(i)) begin
                    case (off[3:0])
                        REG_X:        rd_data = 32'(spr_x_q[i]);
                        REG_Y:        rd_data = 32'(spr_y_q[i]);
                        REG_TEX_BASE: rd_data = 32'(spr_base_q[i]);
                        REG_CTRL:     rd_data = {31'b0, spr_en_q[i]};
                        default:      rd_data = '0;
                    endcase
                end
            end
        end else if (off == BG_ADDR) begin
            rd_data = 32'(bg_q);
        end else if (off == KEY_ADDR) begin
            rd_data = 32'(key_q);
        end else if (off == STATUS_ADDR) begin
            rd_data = {31'b0, overrun_q};
        end
    end

    // Register file only changes from StHost, so it is stable for a whole scan.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                spr_x_q[i]    <= '0;
                spr_y_q[i]    <= '0;
                spr_base_q[i] <= '0;
                spr_en_q[i]   <= 1'b0;
            end
            bg_q  <= '0;
            key_q <= '0;
        end else if (host_wr) begin
            if (spr_sel) begin
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    if (spr_idx == 5'(i)) begin
                        case (off[3:0])
                            REG_X:        spr_x_q[i]    <= dat_i[COORD_W-1:0];
                            REG_Y:        spr_y_q[i]    <= dat_i[COORD_W-1:0];
                            REG_TEX_BASE: spr_base_q[i] <= dat_i[TEX_AW-1:0];
                            REG_CTRL:     spr_en_q[i]   <= dat_i[0];
                            default:      ;
                        endcase
                    end
                end
            end else if (off == BG_ADDR) begin
                bg_q <= dat_i[COLOR_W-1:0];
            end else if (off == KEY_ADDR) begin
                key_q <= dat_i[COLOR_W-1:0];
            end
        end
    end

    // The slot frees up in StEmit, so a request arriving that very cycle is kept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q      <= 1'b0;
            pend_x_q    <= '0;
            pend_y_q    <= '0;
            overrun_q   <= 1'b0;
            host_hold_q <= 1'b0;
        end else begin
            if (cursor_valid_i && (!pend_q || emit)) begin
                pend_q   <= 1'b1;
                pend_x_q <= hcursor_i;
                pend_y_q <= vcursor_i;
            end else if (emit) begin
                pend_q <= 1'b0;
            end
            if (drop) begin
                overrun_q <= 1'b1;
            end else if (status_clr) begin
                overrun_q <= 1'b0;
            end
            if (state_q == StHost) begin
                host_hold_q <= 1'b1;
            end else if (!stb_i) begin
                host_hold_q <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pixel_d   = pixel_q;
        ready_d   = 1'b0;
        ack_d     = 1'b0;
        dat_d     = dat_q;
        tex_stb_d = tex_stb_q;
        tex_adr_d = tex_adr_q;
        unique case (state_q)
            StIdle: begin
                if (stb_i && cyc_i && !host_hold_q) begin
                    state_d = StHost;
                end else if (pend_q) begin
                    state_d = StScan;
                    idx_d   = '0;
                end
            end
            StHost: begin
                ack_d   = 1'b1;
                dat_d   = we_i ? '0 : rd_data;
                state_d = StIdle;
            end
            StScan: begin
                if (hit) begin
                    tex_stb_d = 1'b1;
                    tex_adr_d = hit_adr;
                    state_d   = StTexWait;
                end else if (idx_q == LAST_IDX) begin
                    pixel_d = bg_q;
                    state_d = StEmit;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StTexWait: begin
                if (tex_ack_i) begin
                    tex_stb_d = 1'b0;
                    if (tex_dat_i != key_q) begin
                        pixel_d = tex_dat_i;
                        state_d = StEmit;
                    end else if (idx_q == LAST_IDX) begin
                        pixel_d = bg_q;
                        state_d = StEmit;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StScan;
                    end
                end
            end
            StEmit: begin
                ready_d = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            pixel_q   <= '0;
            ready_q   <= 1'b0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
            tex_stb_q <= 1'b0;
            tex_adr_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pixel_q   <= pixel_d;
            ready_q   <= ready_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            tex_stb_q <= tex_stb_d;
            tex_adr_q <= tex_adr_d;
        end
    end

endmodule
